// File: rtl/tpu_regfile_sb_pkg.sv
// Shared sizing defaults for the tpu_regfile_sb register file and scoreboard.
// Optional build macro: WRITE_BYPASS_EN (same-cycle write-to-read forwarding).
package tpu_regfile_pkg;
   localparam int DATA_W_DEF = 4;
   localparam int ADDR_W_DEF = 2;

   function automatic int nreg(input int addr_w);
      return 1 << addr_w;
   endfunction
endpackage

// File: rtl/tpu_regfile_sb_if.sv
// Decode/write-back facing bus of the register file; master is the core side.
interface tpu_regfile_sb_if
   import tpu_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   localparam int NREG = nreg(ADDR_W);

   logic [ADDR_W-1:0] RD_A_SEL;
   logic [DATA_W-1:0] RD_A_DATA;
   logic [ADDR_W-1:0] RD_B_SEL;
   logic [DATA_W-1:0] RD_B_DATA;
   logic              WR_EN;
   logic [ADDR_W-1:0] WR_SEL;
   logic [DATA_W-1:0] WR_DATA;
   logic              RSV_EN;
   logic [ADDR_W-1:0] RSV_SEL;
   logic              RSV_READY;
   logic              HAZARD_A;
   logic              HAZARD_B;
   logic [NREG-1:0]   BUSY;
   logic [ADDR_W:0]   PEND_CNT;

   modport master (
      output RD_A_SEL, RD_B_SEL, WR_EN, WR_SEL, WR_DATA, RSV_EN, RSV_SEL,
      input  RD_A_DATA, RD_B_DATA, RSV_READY, HAZARD_A, HAZARD_B, BUSY, PEND_CNT
   );

   modport slave (
      input  RD_A_SEL, RD_B_SEL, WR_EN, WR_SEL, WR_DATA, RSV_EN, RSV_SEL,
      output RD_A_DATA, RD_B_DATA, RSV_READY, HAZARD_A, HAZARD_B, BUSY, PEND_CNT
   );
endinterface

// File: rtl/tpu_regfile_sb_scoreboard.sv
// Busy scoreboard: tracks reserved destinations, their count, and read hazards.
module tpu_scoreboard
   import tpu_regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   localparam int NREG  = nreg(ADDR_W)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] rd_a_sel,
   input  logic [ADDR_W-1:0] rd_b_sel,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_sel,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_sel,
   output logic              rsv_ready,
   output logic              haz_a,
   output logic              haz_b,
   output logic [NREG-1:0]   busy,
   output logic [ADDR_W:0]   pend_cnt
);
   localparam int CW = ADDR_W + 1;

   logic [NREG-1:0] busy_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic            inc, dec;

   // A same-cycle write-back frees the slot, so a busy target can be re-reserved.
   assign rsv_ready = !RESET && rsv_en && (!busy[rsv_sel] || (wr_en && (wr_sel == rsv_sel)));
   assign haz_a     = busy[rd_a_sel];
   assign haz_b     = busy[rd_b_sel];

   always_comb begin
      busy_nxt = busy;
      if (wr_en)     busy_nxt[wr_sel]  = 1'b0;
      if (rsv_ready) busy_nxt[rsv_sel] = 1'b1;
      inc     = rsv_ready && !busy[rsv_sel];
      dec     = wr_en && busy[wr_sel] && !(rsv_ready && (rsv_sel == wr_sel));
      cnt_nxt = pend_cnt + CW'(inc) - CW'(dec);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         pend_cnt <= cnt_nxt;
      end
   end
endmodule

// File: rtl/tpu_regfile_sb.sv
// Register file, 1W/2R, with busy scoreboard for multi-cycle producers.
// Optional build macro: WRITE_BYPASS_EN forwards WR_DATA to matching reads.
module tpu_regfile_sb
   import tpu_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic             CLK,
   input logic             RESET,
   tpu_regfile_sb_if.slave bus
);
   localparam int NREG = nreg(ADDR_W);

   logic [NREG-1:0][DATA_W-1:0] regs;
   logic                        haz_a, haz_b;
   logic                        byp_a, byp_b;

   always_ff @(posedge CLK) begin
      if (RESET)          regs              <= '0;
      else if (bus.WR_EN) regs[bus.WR_SEL]  <= bus.WR_DATA;
   end

`ifdef WRITE_BYPASS_EN
   assign byp_a = !RESET && bus.WR_EN && (bus.WR_SEL == bus.RD_A_SEL);
   assign byp_b = !RESET && bus.WR_EN && (bus.WR_SEL == bus.RD_B_SEL);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   assign bus.RD_A_DATA = byp_a ? bus.WR_DATA : regs[bus.RD_A_SEL];
   assign bus.RD_B_DATA = byp_b ? bus.WR_DATA : regs[bus.RD_B_SEL];
   // A forwarded value is the one the hazard was waiting on.
   assign bus.HAZARD_A  = haz_a && !byp_a;
   assign bus.HAZARD_B  = haz_b && !byp_b;

   tpu_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
      .CLK       (CLK),
      .RESET     (RESET),
      .rd_a_sel  (bus.RD_A_SEL),
      .rd_b_sel  (bus.RD_B_SEL),
      .wr_en     (bus.WR_EN),
      .wr_sel    (bus.WR_SEL),
      .rsv_en    (bus.RSV_EN),
      .rsv_sel   (bus.RSV_SEL),
      .rsv_ready (bus.RSV_READY),
      .haz_a     (haz_a),
      .haz_b     (haz_b),
      .busy      (bus.BUSY),
      .pend_cnt  (bus.PEND_CNT)
   );
endmodule

// File: tb/tb_tpu_regfile_sb.sv
// Bench for tpu_regfile_sb: directed vector table plus random run against a model.
module tb_tpu_regfile_sb;
   localparam int DW = 4;
   localparam int AW = 2;
   localparam int NR = 4;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   tpu_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   tpu_regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic          rst, we;
      logic [AW-1:0] ws;
      logic [DW-1:0] wd;
      logic          re;
      logic [AW-1:0] rs, ra, rb;
   } in_t;

   typedef struct packed {
      logic [DW-1:0] a, b;
      logic          rdy, ha, hb;
      logic [NR-1:0] busy;
      logic [AW:0]   pend;
   } out_t;

   typedef struct packed { in_t i; out_t o; } vec_t;

   vec_t vt[$];

   logic [DW-1:0] m_mem [NR];
   bit            m_busy[NR];

   function automatic in_t mki(bit rst, bit we, int ws, int wd, bit re, int rs, int ra, int rb);
      in_t i;
      i.rst = rst; i.we = we; i.ws = AW'(ws); i.wd = DW'(wd);
      i.re = re; i.rs = AW'(rs); i.ra = AW'(ra); i.rb = AW'(rb);
      return i;
   endfunction

   function automatic out_t mko(int a, int b, bit rdy, bit ha, bit hb, int busy, int pend);
      out_t o;
      o.a = DW'(a); o.b = DW'(b); o.rdy = rdy; o.ha = ha; o.hb = hb;
      o.busy = NR'(busy); o.pend = (AW+1)'(pend);
      return o;
   endfunction

   task automatic drive(input in_t i);
      RESET       = i.rst;
      bus.WR_EN   = i.we;  bus.WR_SEL  = i.ws; bus.WR_DATA = i.wd;
      bus.RSV_EN  = i.re;  bus.RSV_SEL = i.rs;
      bus.RD_A_SEL = i.ra; bus.RD_B_SEL = i.rb;
   endtask

   function automatic out_t sample();
      out_t o;
      o.a = bus.RD_A_DATA; o.b = bus.RD_B_DATA; o.rdy = bus.RSV_READY;
      o.ha = bus.HAZARD_A; o.hb = bus.HAZARD_B; o.busy = bus.BUSY; o.pend = bus.PEND_CNT;
      return o;
   endfunction

   task automatic check(input string nm, input out_t exp);
      out_t act;
      act = sample();
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got a=%h b=%h rdy=%b ha=%b hb=%b busy=%b pend=%0d ; want a=%h b=%h rdy=%b ha=%b hb=%b busy=%b pend=%0d",
                  nm, act.a, act.b, act.rdy, act.ha, act.hb, act.busy, act.pend,
                  exp.a, exp.b, exp.rdy, exp.ha, exp.hb, exp.busy, exp.pend);
      end
   endtask

   // Apply inputs for one cycle, check pre-edge outputs at the negedge.
   task automatic cyc(input in_t i, input out_t exp, input string nm);
      drive(i);
      @(negedge CLK);
      check(nm, exp);
      @(posedge CLK); #1;
   endtask

   function automatic out_t model_out(input in_t i);
      out_t o;
      bit   ba, bb;
      int   cnt;
      ba = 1'b0; bb = 1'b0;
`ifdef WRITE_BYPASS_EN
      ba = !i.rst && i.we && (i.ws == i.ra);
      bb = !i.rst && i.we && (i.ws == i.rb);
`endif
      o.a    = ba ? i.wd : m_mem[i.ra];
      o.b    = bb ? i.wd : m_mem[i.rb];
      o.ha   = m_busy[i.ra] && !ba;
      o.hb   = m_busy[i.rb] && !bb;
      o.rdy  = !i.rst && i.re && (!m_busy[i.rs] || (i.we && i.ws == i.rs));
      cnt = 0;
      for (int k = 0; k < NR; k++) begin
         o.busy[k] = m_busy[k];
         cnt += int'(m_busy[k]);
      end
      o.pend = (AW+1)'(cnt);
      return o;
   endfunction

   task automatic model_step(input in_t i, input bit accepted);
      if (i.rst) begin
         for (int k = 0; k < NR; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
      end else begin
         if (i.we) begin m_mem[i.ws] = i.wd; m_busy[i.ws] = 1'b0; end
         if (accepted) m_busy[i.rs] = 1'b1;
      end
   endtask

   initial begin
      in_t  ri;
      out_t ro;

      drive(mki(1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge CLK); #1;

`ifndef WRITE_BYPASS_EN
      //            rst we ws wd  re rs ra rb           a    b   rdy ha hb busy     pend
      vt.push_back({mki(0, 1, 2, 4'hA, 0, 0, 2, 0), mko(0,    0,   0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(1, 0, 0, 0,    0, 0, 2, 0), mko(4'hA, 0,   0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 0, 0, 0,    0, 0, 2, 0), mko(0,    0,   0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 1, 1, 4'h5, 0, 0, 1, 3), mko(0,    0,   0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 1, 3, 4'hC, 0, 0, 1, 3), mko(5,    0,   0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 0, 0, 0,    0, 0, 1, 3), mko(5,    4'hC,0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 0, 0, 0,    1, 2, 2, 3), mko(0,    4'hC,1, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 0, 0, 0,    1, 2, 2, 3), mko(0,    4'hC,0, 1, 0, 4'b0100, 1)});
      vt.push_back({mki(0, 1, 2, 4'h7, 0, 0, 2, 3), mko(0,    4'hC,0, 1, 0, 4'b0100, 1)});
      vt.push_back({mki(0, 0, 0, 0,    0, 0, 2, 3), mko(7,    4'hC,0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 0, 0, 0,    1, 1, 1, 3), mko(5,    4'hC,1, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 1, 1, 4'h3, 1, 1, 1, 3), mko(5,    4'hC,1, 1, 0, 4'b0010, 1)});
      vt.push_back({mki(0, 0, 0, 0,    0, 0, 1, 3), mko(3,    4'hC,0, 1, 0, 4'b0010, 1)});
      vt.push_back({mki(0, 0, 0, 0,    1, 0, 1, 3), mko(3,    4'hC,1, 1, 0, 4'b0010, 1)});
      vt.push_back({mki(0, 0, 0, 0,    1, 2, 1, 3), mko(3,    4'hC,1, 1, 0, 4'b0011, 2)});
      vt.push_back({mki(0, 0, 0, 0,    1, 3, 1, 3), mko(3,    4'hC,1, 1, 0, 4'b0111, 3)});
      vt.push_back({mki(0, 1, 0, 4'hE, 1, 3, 0, 3), mko(0,    4'hC,0, 1, 1, 4'b1111, 4)});
      vt.push_back({mki(1, 0, 0, 0,    1, 1, 0, 3), mko(4'hE, 4'hC,0, 0, 1, 4'b1110, 3)});
      vt.push_back({mki(0, 0, 0, 0,    0, 0, 0, 3), mko(0,    0,   0, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 1, 1, 4'h6, 1, 1, 1, 1), mko(0,    0,   1, 0, 0, 4'b0000, 0)});
      vt.push_back({mki(0, 0, 0, 0,    0, 0, 1, 1), mko(6,    6,   0, 1, 1, 4'b0010, 1)});
      for (int v = 0; v < vt.size(); v++)
         cyc(vt[v].i, vt[v].o, $sformatf("vec%0d", v));
`else
      cyc(mki(0, 0, 0, 0,    1, 0, 0, 1), mko(0, 0, 1, 0, 0, 4'b0000, 0), "byp_rsv");
      cyc(mki(0, 1, 0, 4'h9, 0, 0, 0, 1), mko(9, 0, 0, 0, 0, 4'b0001, 1), "byp_fwd");
      cyc(mki(0, 0, 0, 0,    0, 0, 0, 1), mko(9, 0, 0, 0, 0, 4'b0000, 0), "byp_after");
      cyc(mki(1, 1, 1, 4'h4, 0, 0, 1, 1), mko(0, 0, 0, 0, 0, 4'b0000, 0), "byp_rst");
`endif

      // Random phase: model tracks architectural state, resynced by a reset cycle.
      ri = mki(1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < NR; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
      drive(ri);
      @(posedge CLK); #1;
      for (int n = 0; n < 400; n++) begin
         ri = mki(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, NR-1),
                  $urandom_range(0, 15), ($urandom_range(0, 2) != 0), $urandom_range(0, NR-1),
                  $urandom_range(0, NR-1), $urandom_range(0, NR-1));
         ro = model_out(ri);
         cyc(ri, ro, $sformatf("rnd%0d", n));
         model_step(ri, ro.rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tpu_regfile_sb.md
Name: tpu_regfile_sb

Overview:
Parametrised register file with one write port and two independent read ports.
Adds a per-register busy scoreboard so multi-cycle producers can reserve a destination register, and dependent reads are flagged as hazards until the write-back lands.
Sits between decode (read selects, reservations) and execute/write-back in the tekito core.
Default configuration is 4 registers of 4 bits.

Parameters:
DATA_W, 4, register width in bits
ADDR_W, 2, select width; register count NREG = 2**ADDR_W (derived localparam, not overridable)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high; clears all state
RD_A_SEL  input  ADDR_W  read port A register select
RD_A_DATA  output  DATA_W  read port A data (combinational from state)
RD_B_SEL  input  ADDR_W  read port B register select
RD_B_DATA  output  DATA_W  read port B data (combinational from state)
WR_EN  input  1  write strobe
WR_SEL  input  ADDR_W  write target
WR_DATA  input  DATA_W  write data
RSV_EN  input  1  reservation request for RSV_SEL
RSV_SEL  input  ADDR_W  register to mark busy
RSV_READY  output  1  reservation accepted this cycle
HAZARD_A  output  1  RD_A_SEL register is busy
HAZARD_B  output  1  RD_B_SEL register is busy
BUSY  output  NREG  busy bit vector; bit i corresponds to register i
PEND_CNT  output  ADDR_W+1  number of busy registers, range 0..NREG

Behaviour:
- One clock (CLK). Reset is synchronous and active-high on RESET. RESET has priority over WR_EN and RSV_EN in the same cycle.
- State after a RESET edge: all registers 0, BUSY=0, PEND_CNT=0. As a result RD_A_DATA, RD_B_DATA, HAZARD_A and HAZARD_B all read 0.
- RSV_READY is forced to 0 while RESET=1.
- Reads:
  - RD_x_DATA is the current stored value of register RD_x_SEL.
  - A write becomes visible the cycle after the edge that captures it (1-cycle write-to-read latency).
  - A and B may select the same register.
- Write: on posedge with WR_EN=1 and RESET=0:
  - reg[WR_SEL] <= WR_DATA;
  - BUSY[WR_SEL] <= 0, unless reserved in the same cycle (see below).
  - Writing a non-busy register is legal and leaves BUSY unchanged.
- Reservation:
  - RSV_READY = RSV_EN and (not BUSY[RSV_SEL] or (WR_EN and WR_SEL==RSV_SEL)).
  - If accepted: BUSY[RSV_SEL] <= 1.
  - If RSV_EN=1 and not accepted (register already busy, no same-cycle write-back): no state change; the requester must retry.
- Simultaneous WR and RSV on the same register: data is written and BUSY stays 1 (reservation wins). PEND_CNT is unchanged.
- PEND_CNT is updated in the same edge as BUSY:
  - +1 on an accepted reservation of a non-busy register;
  - -1 on a write to a busy register that is not re-reserved;
  - unchanged otherwise, including a write and a reservation on different registers in the same cycle (+1 and -1 cancel).
  - PEND_CNT always equals popcount(BUSY); no wrap is possible.
- HAZARD_x = BUSY[RD_x_SEL] (combinational).
- No X on any output after the first RESET edge.

Optional Feature:
WRITE_BYPASS_EN.
- Defined: when WR_EN=1 and WR_SEL==RD_x_SEL:
  - RD_x_DATA = WR_DATA in the same cycle (zero-latency forwarding);
  - HAZARD_x = 0 in that cycle, even if BUSY[RD_x_SEL]=1.
  - Bypass is inactive while RESET=1.
- Undefined: no forwarding. Read data and hazards come from stored state only, with the 1-cycle latency above.

Decomposition:
- Package tpu_regfile_pkg: default DATA_W/ADDR_W constants and a function computing NREG from ADDR_W.
- Sub-module tpu_scoreboard: owns BUSY, PEND_CNT, RSV_READY and the hazard lookups.
- The top level holds the data array, the read muxes and the bypass logic, and instantiates tpu_scoreboard.

Test Plan:
- RESET=1 for 1 cycle after writing 4'hA to r2 -> next cycle RD_A_SEL=2 gives 0, BUSY=4'b0000, PEND_CNT=0.
- Write r1=4'h5, r3=4'hC on consecutive cycles; RD_A_SEL=1, RD_B_SEL=3 -> RD_A_DATA=5, RD_B_DATA=C. Without bypass, a same-cycle read of r1 returns the old value 0.
- RSV r2 -> RSV_READY=1, BUSY=4'b0100, PEND_CNT=1, HAZARD_A=1 with RD_A_SEL=2. RSV r2 again -> RSV_READY=0, no change. WR r2=4'h7 -> BUSY=0, PEND_CNT=0, RD_A_DATA=7.
- With r1 busy: same-cycle WR r1=4'h3 and RSV r1 -> RSV_READY=1, BUSY[1] stays 1, PEND_CNT stays 1, r1 reads 3.
- Reserve all 4 registers -> PEND_CNT=4. Then same-cycle WR r0 plus RSV r3 (busy) -> RSV_READY=0, PEND_CNT=3. Then RESET asserted together with RSV r1 -> PEND_CNT=0, RSV_READY=0.
- WRITE_BYPASS_EN defined, r0 busy, WR r0=4'h9, RD_A_SEL=0 -> RD_A_DATA=9 and HAZARD_A=0 in the same cycle.
